// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory load/store path: op and state encodings,
// memory geometry and small request-classification helpers.
package mips_mem_pkg;

    localparam int MEM_ADDR_W = 13;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic is_load(op_t op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    // Byte ops can never be misaligned; halfwords need even, words need 4-aligned.
    function automatic logic misaligned(op_t op, logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW, OP_SW:         bad = (offset != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad = offset[0];
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Big-endian byte-lane steering: load extraction with sign/zero extension, and
// sub-word store merge into a previously read word.
module mips_lsu_lane
    import mips_mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = offset[1] ? word[15:0] : word[31:16];
        case (offset)
            2'd0:    byte_v = word[31:24];
            2'd1:    byte_v = word[23:16];
            2'd2:    byte_v = word[15:8];
            default: byte_v = word[7:0];
        endcase

        load_data = word;
        case (op)
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data = {16'h0000, half_v};
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'h000000, byte_v};
            default: load_data = word;
        endcase

        store_data = wdata;
        case (op)
            OP_SH: store_data = offset[1] ? {word[31:16], wdata[15:0]}
                                          : {wdata[15:0], word[15:0]};
            OP_SB: begin
                case (offset)
                    2'd0:    store_data = {wdata[7:0], word[23:0]};
                    2'd1:    store_data = {word[31:24], wdata[7:0], word[15:0]};
                    2'd2:    store_data = {word[31:16], wdata[7:0], word[7:0]};
                    default: store_data = {word[31:8], wdata[7:0]};
                endcase
            end
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit driving a word-only data memory; sub-word stores are read-modify-write.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_READ  | memread high, read word captured at end of cycle
//   ST_WRITE | memwrite high, memory commits on closing edge
//   ST_RESP  | one-cycle response pulse
module mips_lsu
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state_q, state_d;
    op_t               op_q, req_op_e;
    logic [1:0]        offset_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept, req_err;
    logic [DATA_W-1:0] lane_load, lane_store;

    assign req_op_e  = op_t'(req_op);
    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_err   = (req_addr[31:ADDR_W+2] != '0) || misaligned(req_op_e, req_addr[1:0]);

    mips_lsu_lane u_lane (
        .op         (op_q),
        .offset     (offset_q),
        .word       (mem_read_data),
        .wdata      (wdata_q),
        .load_data  (lane_load),
        .store_data (lane_store)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)                 state_d = ST_RESP;
                    else if (req_op_e == OP_SW)  state_d = ST_WRITE;
                    else                         state_d = ST_READ;
                end
            end
            ST_READ:  state_d = is_load(op_q) ? ST_RESP : ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory strobes and the response pulse are registered off the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_LW;
            offset_q       <= 2'b00;
            wdata_q        <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
        end else begin
            state_q      <= state_d;
            mem_memread  <= (state_d == ST_READ);
            mem_memwrite <= (state_d == ST_WRITE);
            resp_valid   <= (state_d == ST_RESP);

            if (accept) begin
                op_q        <= req_op_e;
                offset_q    <= req_addr[1:0];
                wdata_q     <= req_wdata;
                mem_address <= req_addr[ADDR_W+1:2];
                if (req_err) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end else if (req_op_e == OP_SW) begin
                    mem_write_data <= req_wdata;
                end
            end

            if (state_q == ST_READ) begin
                if (is_load(op_q)) begin
                    resp_err   <= 1'b0;
                    resp_rdata <= lane_load;
                end else begin
                    mem_write_data <= lane_store;
                end
            end

            if (state_q == ST_WRITE) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu with an attached word memory and a reference model
// of memory contents, expected memory events and expected responses.
module tb_mips_lsu;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [12:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [31:0] mem_read_data;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    typedef struct { int c; logic [12:0] a; logic [31:0] d; } mem_ev_t;
    typedef struct { int c; logic e; logic [31:0] d; } resp_ev_t;
    mem_ev_t  rd_q[$];
    mem_ev_t  wr_q[$];
    resp_ev_t rs_q[$];

    logic [31:0] dmem [0:8191];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rdata;
    logic [12:0] last_rd_addr;

    mips_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_read_data = dmem[mem_address];
    always @(posedge clk) if (mem_memwrite) dmem[mem_address] <= mem_write_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---- reference model ----
    function automatic logic [31:0] ref_rd(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    function automatic logic model_err(input logic [2:0] op, input logic [31:0] addr);
        logic e;
        e = (addr >> 15) != 0;
        if ((op == LW || op == SW) && (addr % 4 != 0)) e = 1'b1;
        if ((op == LH || op == LHU || op == SH) && (addr % 2 != 0)) e = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input int off, input logic [31:0] w);
        logic [31:0] v;
        v = w;
        if (op == LH || op == LHU) begin
            v = (w >> (16 * (1 - off / 2))) & 32'h0000FFFF;
            if (op == LH && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else if (op == LB || op == LBU) begin
            v = (w >> (8 * (3 - off))) & 32'h000000FF;
            if (op == LB && v >= 32'h80) v = v | 32'hFFFFFF00;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] op, input int off,
                                                input logic [31:0] w, input logic [31:0] wd);
        int sh;
        logic [31:0] mask;
        if (op == SW) return wd;
        if (op == SH) begin
            sh = 16 * (1 - off / 2);
            mask = 32'h0000FFFF << sh;
        end else begin
            sh = 8 * (3 - off);
            mask = 32'h000000FF << sh;
        end
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic predict(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int acc);
        int idx, off;
        logic [31:0] w, nw;
        idx = int'(addr[14:2]);
        off = int'(addr[1:0]);
        w = ref_rd(idx);
        if (model_err(op, addr)) begin
            rs_q.push_back('{acc + 1, 1'b1, 32'h0});
        end else if (op <= LBU) begin
            rd_q.push_back('{acc + 1, addr[14:2], 32'h0});
            rs_q.push_back('{acc + 2, 1'b0, model_load(op, off, w)});
        end else if (op == SW) begin
            wr_q.push_back('{acc + 1, addr[14:2], wd});
            ref_mem[idx] = wd;
            rs_q.push_back('{acc + 2, 1'b0, 32'h0});
        end else begin
            nw = model_store(op, off, w, wd);
            rd_q.push_back('{acc + 1, addr[14:2], 32'h0});
            wr_q.push_back('{acc + 2, addr[14:2], nw});
            ref_mem[idx] = nw;
            rs_q.push_back('{acc + 3, 1'b0, 32'h0});
        end
    endtask

    // ---- compare process ----
    always @(negedge clk) begin
        mem_ev_t  m;
        resp_ev_t r;
        if (mem_memread || mem_memwrite)
            check("rd_wr_exclusive", {31'b0, mem_memread & mem_memwrite}, 32'h0);
        if (mem_memread) begin
            check("read_expected", {31'b0, rd_q.size() != 0}, 32'h1);
            if (rd_q.size() != 0) begin
                m = rd_q.pop_front();
                check("read_cycle", cyc, m.c);
                check("read_addr", {19'b0, mem_address}, {19'b0, m.a});
                last_rd_addr = mem_address;
            end
        end
        if (mem_memwrite) begin
            check("write_expected", {31'b0, wr_q.size() != 0}, 32'h1);
            if (wr_q.size() != 0) begin
                m = wr_q.pop_front();
                check("write_cycle", cyc, m.c);
                check("write_addr", {19'b0, mem_address}, {19'b0, m.a});
                check("write_data", mem_write_data, m.d);
            end
        end
        if (resp_valid) begin
            check("resp_expected", {31'b0, rs_q.size() != 0}, 32'h1);
            if (rs_q.size() != 0) begin
                r = rs_q.pop_front();
                check("resp_cycle", cyc, r.c);
                check("resp_err", {31'b0, resp_err}, {31'b0, r.e});
                check("resp_rdata", resp_rdata, r.d);
                last_rdata = resp_rdata;
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        #1;
        while ((rd_q.size() + wr_q.size() + rs_q.size()) != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_timeout", rd_q.size() + wr_q.size() + rs_q.size(), 32'h0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        predict(op, addr, wd, cyc);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        issue(op, addr, wd);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int acc;
        for (int i = 0; i < 8192; i++) dmem[i] = 32'h0;
        last_rdata = 32'h0;
        last_rd_addr = 13'h0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_memread", {31'b0, mem_memread}, 32'h0);
        check("rst_memwrite", {31'b0, mem_memwrite}, 32'h0);
        check("rst_mem_address", {19'b0, mem_address}, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        rst_n = 1'b1;

        do_req(SW, 32'h0, 32'h12345678);
        do_req(LW, 32'h0, 32'h0);
        check("lit_lw0", last_rdata, 32'h12345678);

        do_req(SB, 32'h1, 32'h000000AB);
        check("lit_dmem_after_sb", dmem[0], 32'h12AB5678);
        do_req(LW, 32'h0, 32'h0);
        check("lit_lw_after_sb", last_rdata, 32'h12AB5678);

        do_req(LB, 32'h1, 32'h0);
        check("lit_lb1", last_rdata, 32'hFFFFFFAB);
        do_req(LBU, 32'h1, 32'h0);
        check("lit_lbu1", last_rdata, 32'h000000AB);
        do_req(LH, 32'h2, 32'h0);
        check("lit_lh2", last_rdata, 32'h00005678);
        do_req(SH, 32'h2, 32'hFFFF8001);
        do_req(LH, 32'h2, 32'h0);
        check("lit_lh2_after_sh", last_rdata, 32'hFFFF8001);
        do_req(LHU, 32'h0, 32'h0);
        check("lit_lhu0", last_rdata, 32'h000012AB);
        do_req(LB, 32'h3, 32'h0);
        check("lit_lb3", last_rdata, 32'h00000001);

        do_req(LH, 32'h1, 32'h0);
        check("lit_lh1_rdata", last_rdata, 32'h0);
        do_req(SW, 32'h6, 32'hDEADBEEF);
        do_req(LW, 32'h8000, 32'h0);
        do_req(SB, 32'h0001_0003, 32'h77);

        do_req(SW, 32'h7FFC, 32'hCAFEF00D);
        do_req(LW, 32'h7FFC, 32'h0);
        check("lit_top_addr", {19'b0, last_rd_addr}, 32'h00001FFF);
        check("lit_top_data", last_rdata, 32'hCAFEF00D);

        // SB aborted by reset during its READ cycle: the read happens, nothing else.
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        req_op    = SB;
        req_addr  = 32'h1;
        req_wdata = 32'h55;
        acc = cyc;
        rd_q.push_back('{acc + 1, 13'h0, 32'h0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", {31'b0, req_ready}, 32'h1);
        check("abort_memwrite", {31'b0, mem_memwrite}, 32'h0);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'h0);
        repeat (3) @(negedge clk);
        wait_drain();
        check("abort_dmem", dmem[0], 32'h12AB8001);
        do_req(LW, 32'h0, 32'h0);
        check("lit_after_abort", last_rdata, 32'h12AB8001);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
